// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: latches ALU result and controls, resolves BEQ/BNE and the branch target.
// Define EX_MEM_OVF_TRAP_EN to turn signed add/sub overflow into a precise exception bubble.
module ex_mem_latch #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu_out,
    input  logic          ex_zero,
    input  logic          ex_overflow,
    input  logic [DW-1:0] ex_pc4,
    input  logic [DW-1:0] ex_imm,
    input  logic          ex_beq,
    input  logic          ex_bne,
    input  logic          ex_ovf_chk,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    input  logic          ex_memtoreg,
    output logic          mem_valid,
    output logic [DW-1:0] mem_alu_out,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_regwrite,
    output logic          mem_memread,
    output logic          mem_memwrite,
    output logic          mem_memtoreg,
    output logic          br_taken,
    output logic [DW-1:0] br_target,
    output logic          exc_ovf,
    output logic [DW-1:0] epc
);

    logic          w_taken;
    logic          w_fault;
    logic          w_bubble;
    logic [DW-1:0] w_target;

    logic          r_valid;
    logic [DW-1:0] r_alu_out;
    logic [DW-1:0] r_store_data;
    logic [RW-1:0] r_rd;
    logic          r_regwrite;
    logic          r_memread;
    logic          r_memwrite;
    logic          r_memtoreg;
    logic          r_br_taken;
    logic [DW-1:0] r_br_target;

    assign w_taken  = (ex_beq & ex_zero) | (ex_bne & ~ex_zero);
    assign w_target = ex_pc4 + (ex_imm << 2);
    // An empty EX slot loads the same bubble a flush would
    assign w_bubble = flush | (~stall & ~ex_valid);

    always_ff @(posedge CLK) begin
        if (RST || w_bubble) begin
            r_valid      <= 1'b0;
            r_alu_out    <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_br_taken   <= 1'b0;
            r_br_target  <= '0;
        end else if (!stall) begin
            r_valid      <= 1'b1;
            r_alu_out    <= ex_alu_out;
            r_store_data <= ex_store_data;
            r_rd         <= ex_rd;
            // A faulting instruction keeps its slot but must not write anything
            r_regwrite   <= ex_regwrite & ~w_fault;
            r_memread    <= ex_memread  & ~w_fault;
            r_memwrite   <= ex_memwrite & ~w_fault;
            r_memtoreg   <= ex_memtoreg & ~w_fault;
            r_br_taken   <= w_taken;
            r_br_target  <= w_target;
        end
    end

`ifdef EX_MEM_OVF_TRAP_EN
    logic          r_exc_ovf;
    logic [DW-1:0] r_epc;

    assign w_fault = ex_valid & ex_ovf_chk & ex_overflow;

    // epc is sticky: only RST or a new fault load changes it
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_exc_ovf <= 1'b0;
            r_epc     <= '0;
        end else if (w_bubble) begin
            r_exc_ovf <= 1'b0;
        end else if (!stall) begin
            r_exc_ovf <= w_fault;
            if (w_fault) begin
                r_epc <= ex_pc4 - DW'(4);
            end
        end
    end

    assign exc_ovf = r_exc_ovf;
    assign epc     = r_epc;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = ex_ovf_chk ^ ex_overflow;
    assign w_fault      = 1'b0;
    assign exc_ovf      = 1'b0;
    assign epc          = '0;
`endif

    assign mem_valid      = r_valid;
    assign mem_alu_out    = r_alu_out;
    assign mem_store_data = r_store_data;
    assign mem_rd         = r_rd;
    assign mem_regwrite   = r_regwrite;
    assign mem_memread    = r_memread;
    assign mem_memwrite   = r_memwrite;
    assign mem_memtoreg   = r_memtoreg;
    assign br_taken       = r_br_taken;
    assign br_target      = r_br_target;

endmodule
